// File: rtl/accum_sched_pkg.sv
// Shared formats, FSM encoding and the round-robin pick used by accum_sched.
package accum_sched_pkg;

  localparam int IN_W   = 16;
  localparam int ACC_W  = 20;
  localparam int FRAC_W = 12;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  // First set bit of req at or after ptr, wrapping modulo n (n <= 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int n);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !found && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/accumulator.sv
// Q8.12 running sum of sign-extended Q4.12 samples, wrapping modulo 2^ACC_W.
module accumulator
  import accum_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             data_en,
  input  logic [IN_W-1:0]  data_in,
  output logic [ACC_W-1:0] acc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (data_en) begin
      acc <= acc + {{(ACC_W-IN_W){data_in[IN_W-1]}}, data_in};
    end
  end

endmodule

// File: rtl/accum_sched.sv
// Round-robin owner of one shared accumulator: grant, clear, stream a burst, hand back the sum.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; valid,
// once raised, holds with stable payload until that edge.
module accum_sched
  import accum_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LEN_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*LEN_W-1:0]     req_len,
  input  logic [N_REQ*16-1:0]        in_data,
  input  logic [N_REQ-1:0]           in_valid,
  output logic [N_REQ-1:0]           in_ready,
  output logic [N_REQ-1:0]           grant,
  output logic [19:0]                res_data,
  output logic [$clog2(N_REQ)-1:0]   res_id,
  output logic                       res_ovf,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       busy
);

  localparam int ID_W = $clog2(N_REQ);

  state_t           state;
  logic [ID_W-1:0]  id, ptr, pick, id_next;
  logic [LEN_W-1:0] len, cnt;
  logic             ovf_flag;
  logic [IN_W-1:0]  sample;
  logic [ACC_W-1:0] acc, ext, sum;
  logic             hs, ovf_now, last;

  assign pick    = ID_W'(rr_pick(8'(req), 3'(ptr), N_REQ));
  assign id_next = (id == ID_W'(N_REQ-1)) ? '0 : id + ID_W'(1);
  assign sample  = in_data[id*IN_W +: IN_W];
  assign hs      = (state == RUN) && in_valid[id];
  assign last    = (cnt == len - LEN_W'(1));

  // Overflow is judged on the same operands the accumulator is about to add.
  assign ext     = {{(ACC_W-IN_W){sample[IN_W-1]}}, sample};
  assign sum     = acc + ext;
  assign ovf_now = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

  always_comb begin
    in_ready = '0;
    if (state == RUN) in_ready[id] = 1'b1;
  end

  assign res_data = acc;
  assign res_id   = id;
  assign res_ovf  = ovf_flag;

  accumulator u_acc (
    .clk     (clk),
    .reset   (reset | (state == CLEAR)),
    .data_en (hs),
    .data_in (sample),
    .acc     (acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      id        <= '0;
      ptr       <= '0;
      len       <= '0;
      cnt       <= '0;
      ovf_flag  <= 1'b0;
      grant     <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            id    <= pick;
            len   <= req_len[pick*LEN_W +: LEN_W];
            grant <= N_REQ'(1) << pick;
            busy  <= 1'b1;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          cnt      <= '0;
          ovf_flag <= 1'b0;
          if (len != '0) begin
            state <= RUN;
          end else begin
            state     <= DONE;
            res_valid <= 1'b1;
          end
        end
        RUN: begin
          if (hs) begin
            cnt      <= cnt + LEN_W'(1);
            ovf_flag <= ovf_flag | ovf_now;
            if (last) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            ptr       <= id_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_sched.sv
// Directed bench for accum_sched with hand-computed expectations.
module tb_accum_sched;

  localparam int N_REQ = 4;
  localparam int LEN_W = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*LEN_W-1:0] req_len;
  logic [N_REQ*16-1:0]    in_data;
  logic [N_REQ-1:0]       in_valid;
  logic [N_REQ-1:0]       in_ready;
  logic [N_REQ-1:0]       grant;
  logic [19:0]            res_data;
  logic [1:0]             res_id;
  logic                   res_ovf;
  logic                   res_valid;
  logic                   res_ready;
  logic                   busy;

  int n_checks = 0;
  int n_pass   = 0;
  int hs_cnt   = 0;
  int n;

  always #5 clk = ~clk;

  accum_sched #(.N_REQ(N_REQ), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_len   (req_len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .grant     (grant),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ovf   (res_ovf),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
  );

  always @(posedge clk) if (|(in_valid & in_ready)) hs_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_res(input int max, output int edges);
    edges = 0;
    while (!res_valid && edges < max) begin
      tick();
      edges++;
    end
    check("res_valid_timeout", 32'(res_valid), 32'd1);
  endtask

  task automatic wait_grant(input int max);
    int e = 0;
    while (grant == '0 && e < max) begin
      tick();
      e++;
    end
    check("grant_timeout", 32'(grant != '0), 32'd1);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},     32'(grant),     32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"},  32'(res_data),  32'd0);
    check({tag, "_res_id"},    32'(res_id),    32'd0);
    check({tag, "_res_ovf"},   32'(res_ovf),   32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_len   = '0;
    in_data   = '0;
    in_valid  = '0;
    res_ready = 1'b0;
    tick();
    do_reset();
    check_reset_outputs("rst");

    // Single burst: 4 x 1.0 on requester 0, latency counted from the sampling edge.
    req_len[0 +: LEN_W] = 8'd4;
    in_data[0 +: 16]    = 16'h1000;
    in_valid            = 4'b0001;
    req                 = 4'b0001;
    tick();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_busy", 32'(busy), 32'd1);
    req = '0;
    wait_res(20, n);
    check("t1_latency", 32'(n + 1), 32'd6);
    check("t1_data", 32'(res_data), 32'h04000);
    check("t1_id", 32'(res_id), 32'd0);
    check("t1_ovf", 32'(res_ovf), 32'd0);
    accept();
    check("t1_idle_grant", 32'(grant), 32'd0);

    // Round robin with everyone requesting.
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      req_len[i*LEN_W +: LEN_W] = 8'd1;
      in_data[i*16 +: 16]       = 16'h1000;
    end
    in_valid  = 4'b1111;
    req       = 4'b1111;
    res_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      wait_grant(10);
      check($sformatf("t2_grant%0d", b), 32'(grant), 32'(4'b0001 << (b % 4)));
      wait_res(10, n);
      check($sformatf("t2_data%0d", b), 32'(res_data), 32'h01000);
      check($sformatf("t2_id%0d", b), 32'(res_id), 32'(b % 4));
      if (b == 4) req = '0;
      tick();
    end
    res_ready = 1'b0;
    in_valid  = '0;

    // 17 x 0x7FFF on requester 1: wraps past +8.0, overflow sticks.
    req_len[1*LEN_W +: LEN_W] = 8'd17;
    in_data[1*16 +: 16]       = 16'h7FFF;
    in_valid = 4'b0010;
    req      = 4'b0010;
    tick();
    req = '0;
    wait_res(40, n);
    check("t3_data", 32'(res_data), 32'h87FEF);
    check("t3_ovf", 32'(res_ovf), 32'd1);
    check("t3_id", 32'(res_id), 32'd1);
    accept();

    // Gapped valid on requester 2: two -1.0 samples.
    req_len[2*LEN_W +: LEN_W] = 8'd2;
    in_data[2*16 +: 16]       = 16'hF000;
    in_valid = 4'b0000;
    req      = 4'b0100;
    tick();
    req    = '0;
    hs_cnt = 0;
    n      = 0;
    while (!res_valid && n < 30) begin
      in_valid[2] = (n % 2 == 0);
      tick();
      n++;
    end
    in_valid = '0;
    check("t4_valid", 32'(res_valid), 32'd1);
    check("t4_pulses", 32'(hs_cnt), 32'd2);
    check("t4_data", 32'(res_data), 32'hFE000);
    check("t4_ovf", 32'(res_ovf), 32'd0);
    accept();

    // Zero-length burst on requester 3.
    req_len[3*LEN_W +: LEN_W] = 8'd0;
    req = 4'b1000;
    tick();
    req = '0;
    wait_res(10, n);
    check("t4z_latency", 32'(n + 1), 32'd2);
    check("t4z_data", 32'(res_data), 32'd0);
    check("t4z_ovf", 32'(res_ovf), 32'd0);
    check("t4z_id", 32'(res_id), 32'd3);
    accept();

    // Backpressure in DONE with another request pending.
    req_len[0 +: LEN_W] = 8'd1;
    req_len[1*LEN_W +: LEN_W] = 8'd1;
    in_data[0 +: 16] = 16'h1000;
    in_data[16 +: 16] = 16'h1000;
    in_valid = 4'b0011;
    req      = 4'b0011;
    wait_res(10, n);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("t5_valid%0d", c), 32'(res_valid), 32'd1);
      check($sformatf("t5_data%0d", c), 32'(res_data), 32'h01000);
      check($sformatf("t5_id%0d", c), 32'(res_id), 32'd0);
      check($sformatf("t5_grant%0d", c), 32'(grant), 32'h1);
    end
    accept();
    check("t5_idle_gap", 32'(grant), 32'd0);
    tick();
    check("t5_next_grant", 32'(grant), 32'h2);
    req = '0;
    wait_res(10, n);
    check("t5_id1", 32'(res_id), 32'd1);
    accept();

    // Reset mid-burst on requester 2 after two samples.
    req_len[2*LEN_W +: LEN_W] = 8'd4;
    in_data[2*16 +: 16]       = 16'h1000;
    in_valid = 4'b0100;
    req      = 4'b0100;
    tick();
    hs_cnt = 0;
    n      = 0;
    while (hs_cnt < 2 && n < 20) begin
      tick();
      n++;
    end
    check("t6_two_samples", 32'(hs_cnt), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req   = '0;
    check_reset_outputs("t6");
    tick();
    check("t6_no_result", 32'(res_valid), 32'd0);
    req = 4'b1101;
    tick();
    check("t6_grant_after_reset", 32'(grant), 32'h1);
    req = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/accum_sched.md
# accum_sched

Round-robin scheduler that shares one Q8.12 `accumulator` datapath between `N_REQ` requesters. Each requester asks for a burst of `len` Q4.12 samples. The scheduler grants one requester, clears the accumulator, and streams that requester's samples into it under a valid/ready handshake. It then returns the tagged sum with a sticky overflow flag on a result handshake. It sits between the sample producers and the downstream consumer of block sums.

## Interface

- `N_REQ`, default 4: number of requesters, 2..8.
- `LEN_W`, default 8: burst-length field width. Length range is 0..2^LEN_W-1.
- `clk` input, 1 bit: the single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `req` input, `N_REQ` bits: per-requester burst request, level.
- `req_len` input, `N_REQ*LEN_W` bits: per-requester burst length, sampled only at grant.
- `in_data` input, `N_REQ*16` bits: per-requester sample, signed Q4.12.
- `in_valid` input, `N_REQ` bits: per-requester sample valid.
- `in_ready` output, `N_REQ` bits: sample accepted when `in_valid[i] & in_ready[i]`.
- `grant` output, `N_REQ` bits: one-hot owner of the current burst; 0 when idle.
- `res_data` output, 20 bits: signed Q8.12 burst sum.
- `res_id` output, `$clog2(N_REQ)` bits: index of the requester owning `res_data`.
- `res_ovf` output, 1 bit: at least one accumulation in this burst overflowed.
- `res_valid` output, 1 bit: result available.
- `res_ready` input, 1 bit: consumer accepts the result.
- `busy` output, 1 bit: state is not IDLE.

## Operation

- State machine: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - If `req` is nonzero, select a requester by round-robin. Search starts at `ptr`, ascending modulo `N_REQ`.
  - Latch `id` and `len`, set `grant`, go to CLEAR.
  - If `req` is zero, stay in IDLE.
- CLEAR:
  - Accumulator reset asserted for exactly one cycle. `cnt` is cleared to 0 and the overflow flag is cleared.
  - Next state is RUN if `len` is nonzero, otherwise DONE.
- RUN:
  - `in_ready[id]` is 1 and all other `in_ready` bits are 0.
  - On each handshake: pulse accumulator `data_en`, mux `in_data[id]` into the accumulator, increment `cnt`, and OR the overflow flag with `ovf_now`.
  - The handshake with `cnt == len-1` moves the state to DONE.
  - Cycles with `in_valid[id]` low are idle; `data_en` stays 0.
- DONE:
  - `res_valid` is 1; `res_data` is driven from the accumulator output, `res_id` from `id`, `res_ovf` from the flag. All are stable until accepted.
  - `res_valid & res_ready` returns the state to IDLE, clears `grant`, and sets `ptr` to `id+1` modulo `N_REQ`.
- Arithmetic:
  - Sample is sign-extended 16 to 20 bits. The sum wraps modulo 2^20.
  - `ovf_now` is set when both operand signs are equal and the result sign differs.
  - The flag is sticky for the burst and is not cleared if the sum later wraps back into range.
- Boundary cases:
  - `req[id]` deasserted mid-burst is ignored; the burst runs to `len` samples.
  - `req_len` changes after grant are ignored.
  - A zero-length burst yields `res_data` = 0 and `res_ovf` = 0.
  - A new grant is never issued while in DONE, including when `res_ready` is held low.
  - `reset` asserted in any state forces IDLE at the next edge. The accumulator clears, `ptr` returns to 0, and any burst in flight is discarded with no result.

## Timing

- Reset values: `grant`=0, `in_ready`=0, `res_valid`=0, `res_data`=0, `res_id`=0, `res_ovf`=0, `busy`=0, `ptr`=0.
- `grant`, `res_valid`, `res_id`, `res_ovf` and `busy` are registered. `in_ready` is decoded from the registered state and `id`.
- `req` is sampled at edge k in IDLE:
  - `grant` is visible after edge k.
  - The accumulator clears at edge k+1.
  - The first sample can be accepted at edge k+2.
- The last sample is accepted at edge t. `res_valid` rises after edge t and `res_data` already includes that sample.
- With `in_valid` held high, `res_valid` rises L+2 edges after `req` is sampled; for `len` = 0 this is 2 edges.
- Result accepted at edge r: the next grant is visible at the earliest after edge r+1, because IDLE lasts at least one cycle.

## Structure

- Package `accum_sched_pkg` holds:
  - Format constants: `IN_W`=16, `ACC_W`=20, `FRAC_W`=12.
  - The state enum: IDLE, CLEAR, RUN, DONE.
  - A round-robin pick function.
- One sub-module: the existing `accumulator`, instantiated as the datapath.
  - Its `reset` is driven by `reset | (state==CLEAR)`.
  - Its `data_en` is driven by the RUN handshake.
  - Its `data_in` is the muxed `in_data[id]`.
- Overflow detection lives in `accum_sched` and uses the accumulator output and the muxed input.

## Test plan

- Reset, then `req`=4'b0001 with `len`=4 and four samples of 0x1000 → `res_data`=0x04000, `res_id`=0, `res_ovf`=0, `res_valid` rising 6 edges after `req` is sampled.
- `req`=4'b1111 held, all `len`=1, data 0x1000, `res_ready`=1 → grant order 0,1,2,3,0 and every `res_data`=0x01000.
- `len`=17 with samples of 0x7FFF → `res_data`=0x87FEF, `res_ovf`=1.
- `in_valid` toggling 1,0,1,0 with `len`=2 and samples 0xF000, 0xF000 (-1.0 each) → exactly 2 `data_en` pulses, `res_data`=0xFE000. Then `len`=0 → `res_data`=0 two edges after `req` is sampled.
- `res_ready` held low for 5 cycles in DONE with other requests pending → `res_valid` held, outputs stable, `grant` unchanged, no new grant.
- `reset` asserted in RUN after 2 of 4 samples → all outputs at reset values next cycle, no result produced, and the next grant goes to requester 0.
